// File: rtl/warp_simd_alu.sv
// Pipelined SIMD integer ALU: one opcode across LANES signed lanes per transaction,
// with per-lane masking, optional saturation, overflow flags, sticky status and an event counter.
module warp_simd_alu #(
    parameter int WIDTH   = 32,
    parameter int LANES   = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic                   in_sat,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [LANES*WIDTH-1:0] in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [LANES-1:0]       out_ovf,
    input  logic                   clr_status,
    output logic [LANES-1:0]       sticky_ovf,
    output logic [CNT_W-1:0]       ovf_count
);

    localparam int EW = 2 * WIDTH + 1;
    localparam int VW = LANES * WIDTH;

    typedef logic signed [EW-1:0] wide_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_FMA  = 3'd3,
        OP_MAX  = 3'd4,
        OP_MIN  = 3'd5,
        OP_RELU = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    localparam wide_t MAX_V = {{(EW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam wide_t MIN_V = {{(EW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Exact per-lane result; EW bits hold the full product plus an addend without loss.
    function automatic wide_t lane_exact(input op_e op,
                                         input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b,
                                         input logic signed [WIDTH-1:0] c);
        wide_t ax;
        wide_t bx;
        wide_t cx;
        ax = {{(EW - WIDTH){a[WIDTH-1]}}, a};
        bx = {{(EW - WIDTH){b[WIDTH-1]}}, b};
        cx = {{(EW - WIDTH){c[WIDTH-1]}}, c};
        case (op)
            OP_ADD:  return ax + bx;
            OP_SUB:  return ax - bx;
            OP_MUL:  return ax * bx;
            OP_FMA:  return ax * bx + cx;
            OP_MAX:  return (ax > bx) ? ax : bx;
            OP_MIN:  return (ax < bx) ? ax : bx;
            OP_RELU: return ax[EW-1] ? '0 : ax;
            default: return ax;
        endcase
    endfunction

    function automatic logic lane_ovf(input wide_t x);
        return (x > MAX_V) || (x < MIN_V);
    endfunction

    function automatic logic [WIDTH-1:0] lane_sat(input wide_t x, input logic sat);
        if (sat && (x > MAX_V)) begin
            return MAX_V[WIDTH-1:0];
        end else if (sat && (x < MIN_V)) begin
            return MIN_V[WIDTH-1:0];
        end else begin
            return x[WIDTH-1:0];
        end
    endfunction

    logic             adv;
    logic [VW-1:0]    res_c;
    logic [LANES-1:0] ovf_c;

    logic [LATENCY-1:0] vld_p;
    logic [VW-1:0]      res_p [LATENCY];
    logic [LANES-1:0]   ovf_p [LATENCY];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin : stage0_calc
        wide_t ex;
        ex    = '0;
        res_c = '0;
        ovf_c = '0;
        for (int i = 0; i < LANES; i++) begin
            ex = lane_exact(op_e'(in_op), in_a[i*WIDTH +: WIDTH],
                            in_b[i*WIDTH +: WIDTH], in_c[i*WIDTH +: WIDTH]);
            if (in_mask[i]) begin
                res_c[i*WIDTH +: WIDTH] = lane_sat(ex, in_sat);
                ovf_c[i]                = lane_ovf(ex);
            end
        end
    end

    // ---- stage 0 capture, stages 1..LATENCY-1 are plain delay registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int s = 1; s < LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            res_p[0] <= res_c;
            ovf_p[0] <= ovf_c;
            for (int s = 1; s < LATENCY; s++) begin
                res_p[s] <= res_p[s-1];
                ovf_p[s] <= ovf_p[s-1];
            end
        end
    end

    // ---- output stage: data is gated by valid so reset shows zeros ----
    assign out_valid  = vld_p[LATENCY-1];
    assign out_result = out_valid ? res_p[LATENCY-1] : '0;
    assign out_ovf    = out_valid ? ovf_p[LATENCY-1] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= '0;
            ovf_count  <= '0;
        end else if (clr_status) begin
            sticky_ovf <= '0;
            ovf_count  <= '0;
        end else if (out_valid && out_ready) begin
            sticky_ovf <= sticky_ovf | out_ovf;
            if ((|out_ovf) && (ovf_count != {CNT_W{1'b1}})) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_warp_simd_alu.sv
// Directed bench for warp_simd_alu: arithmetic, overflow/saturation, masking,
// backpressure, asynchronous reset and counter saturation (second instance with CNT_W=2).
module tb_warp_simd_alu;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:0]   in_op;
    logic         in_sat;
    logic [3:0]   in_mask;
    logic [127:0] in_a, in_b, in_c;
    logic         out_ready;
    logic         clr_status;

    logic         in_ready, out_valid;
    logic [127:0] out_result;
    logic [3:0]   out_ovf, sticky_ovf;
    logic [15:0]  ovf_count;

    logic         in_ready2, out_valid2;
    logic [127:0] out_result2;
    logic [3:0]   out_ovf2, sticky_ovf2;
    logic [1:0]   ovf_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    warp_simd_alu #(.WIDTH(32), .LANES(4), .LATENCY(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sat(in_sat), .in_mask(in_mask),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .clr_status(clr_status), .sticky_ovf(sticky_ovf),
        .ovf_count(ovf_count)
    );

    warp_simd_alu #(.WIDTH(32), .LANES(4), .LATENCY(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_sat(in_sat), .in_mask(in_mask),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_ovf(out_ovf2), .clr_status(clr_status), .sticky_ovf(sticky_ovf2),
        .ovf_count(ovf_count2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Issue one transaction from a negedge and check it arrives exactly two cycles later.
    task automatic do_op(input string tag, input logic [2:0] op, input logic sat,
                         input logic [3:0] mask, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] c, input logic [127:0] exp_res,
                         input logic [3:0] exp_ovf);
        in_op = op; in_sat = sat; in_mask = mask;
        in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_op = 3'd7; in_sat = ~sat; in_mask = 4'h0;
        in_a = '1; in_b = '1; in_c = '1;
        #1;
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] va, vb, prev_res;
        logic         stall_prev, acc;
        int           sent, got, cyc;

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_sat = 1'b0; in_mask = 4'h0;
        in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1; clr_status = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_vld", out_valid, 0);
        check("rst_res", out_result, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_sticky", sticky_ovf, 0);
        check("rst_cnt", ovf_count, 0);
        check("rst_rdy", in_ready, 1);
        rst = 1'b0;

        // Basic arithmetic
        do_op("add", 3'd0, 1'b0, 4'hF, pk(0, 0, 0, 32'h10), pk(0, 0, 0, 32'h20), '0,
              pk(0, 0, 0, 32'h30), 4'h0);
        do_op("mul", 3'd2, 1'b0, 4'hF, pk(0, 0, 0, 32'd5), pk(0, 0, 0, 32'd6), '0,
              pk(0, 0, 0, 32'h1E), 4'h0);
        do_op("fma", 3'd3, 1'b0, 4'hF, pk(0, 0, 0, 32'd2), pk(0, 0, 0, 32'd3),
              pk(0, 0, 0, 32'd4), pk(0, 0, 0, 32'hA), 4'h0);
        @(posedge clk); @(negedge clk); #1;
        check("basic_cnt", ovf_count, 0);

        // Overflow: wrap vs clamp
        do_op("add_wrap", 3'd0, 1'b0, 4'hF, pk(0, 0, 0, 32'h7FFFFFFF), pk(0, 0, 0, 32'd1), '0,
              pk(0, 0, 0, 32'h80000000), 4'h1);
        do_op("add_sat", 3'd0, 1'b1, 4'hF, pk(0, 0, 0, 32'h7FFFFFFF), pk(0, 0, 0, 32'd1), '0,
              pk(0, 0, 0, 32'h7FFFFFFF), 4'h1);
        do_op("mul_sat", 3'd2, 1'b1, 4'hF, pk(0, 0, 0, 32'h80000000),
              pk(0, 0, 0, 32'hFFFFFFFF), '0, pk(0, 0, 0, 32'h7FFFFFFF), 4'h1);
        @(posedge clk); @(negedge clk); #1;
        check("ovf_sticky", sticky_ovf, 4'h1);
        check("ovf_cnt", ovf_count, 3);
        check("ovf_cnt2", ovf_count2, 3);

        // Four-lane compare ops and masking
        va = pk(32'hFFFFFFF9, 32'h10, 32'd5, 32'hFFFFFFFF);
        vb = pk(32'hFFFFFFF8, 32'h20, 32'd5, 32'h0);
        do_op("max", 3'd4, 1'b0, 4'hF, va, vb, '0,
              pk(32'hFFFFFFF9, 32'h20, 32'd5, 32'h0), 4'h0);
        do_op("min", 3'd5, 1'b0, 4'hF, va, vb, '0,
              pk(32'hFFFFFFF8, 32'h10, 32'd5, 32'hFFFFFFFF), 4'h0);
        do_op("relu", 3'd6, 1'b0, 4'hF, va, vb, '0,
              pk(32'h0, 32'h10, 32'd5, 32'h0), 4'h0);
        do_op("min_mask", 3'd5, 1'b0, 4'b0101, va, vb, '0,
              pk(32'h0, 32'h10, 32'h0, 32'hFFFFFFFF), 4'h0);
        do_op("sub", 3'd1, 1'b0, 4'hF, pk(0, 0, 0, 32'h10), pk(0, 0, 0, 32'h30), '0,
              pk(0, 0, 0, 32'hFFFFFFE0), 4'h0);
        do_op("mask_ovf", 3'd0, 1'b0, 4'b1101, pk(0, 0, 32'h7FFFFFFF, 32'd1),
              pk(0, 0, 32'd1, 32'd2), '0, pk(0, 0, 0, 32'd3), 4'h0);
        do_op("fma_negsat", 3'd3, 1'b1, 4'hF, pk(0, 0, 0, 32'h80000000), pk(0, 0, 0, 32'd1),
              pk(0, 0, 0, 32'hFFFFFFFF), pk(0, 0, 0, 32'h80000000), 4'h1);
        @(posedge clk); @(negedge clk);

        // Backpressure: six back-to-back ADDs with a 4-cycle downstream stall
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; prev_res = '0;
        in_op = 3'd0; in_sat = 1'b0; in_mask = 4'hF; in_c = '0;
        while (got < 6 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (sent < 6);
            in_a = pk(0, 0, 0, 32'(32'h100 + sent));
            in_b = pk(0, 0, 0, 32'(sent));
            #1;
            if (stall_prev && out_valid) check("bp_hold", out_result, prev_res);
            if (out_valid && !out_ready) check("bp_rdy", in_ready, 0);
            if (out_valid && out_ready) begin
                check("bp_res", out_result, pk(0, 0, 0, 32'(32'h100 + 2 * got)));
                got++;
            end
            acc        = in_valid && in_ready;
            stall_prev = out_valid && !out_ready;
            prev_res   = out_result;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_got", got, 6);
        check("bp_sent", sent, 6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("bp_idle", out_valid, 0);
        end

        // Asynchronous reset with two transactions in flight
        in_op = 3'd7; in_mask = 4'hF; in_a = pk(0, 0, 0, 32'h55); in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_a = pk(0, 0, 0, 32'h66);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; #1;
        check("rf_pre", out_valid, 1);
        rst = 1'b1; #1;
        check("rf_async", out_valid, 0);
        check("rf_async2", out_valid2, 0);
        check("rf_res", out_result, 0);
        check("rf_sticky", sticky_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("rf_stale", out_valid, 0);
        end

        // Counter saturation (CNT_W=2 instance) and clear priority
        for (int k = 0; k < 5; k++) begin
            do_op("cnt_ovf", 3'd0, 1'b0, 4'hF, pk(0, 0, 0, 32'h7FFFFFFF), pk(0, 0, 0, 32'd1),
                  '0, pk(0, 0, 0, 32'h80000000), 4'h1);
        end
        @(posedge clk); @(negedge clk); #1;
        check("cnt_sat2", ovf_count2, 3);
        check("cnt_full", ovf_count, 5);
        do_op("clr_ovf", 3'd0, 1'b0, 4'hF, pk(0, 0, 0, 32'h7FFFFFFF), pk(0, 0, 0, 32'd1),
              '0, pk(0, 0, 0, 32'h80000000), 4'h1);
        clr_status = 1'b1;
        @(posedge clk); @(negedge clk);
        clr_status = 1'b0; #1;
        check("clr_cnt", ovf_count, 0);
        check("clr_cnt2", ovf_count2, 0);
        check("clr_sticky", sticky_ovf, 0);
        check("clr_sticky2", sticky_ovf2, 0);
        check("clr_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/warp_simd_alu.md
Name: warp_simd_alu

Overview:
- Parametrised, pipelined SIMD integer ALU executing one opcode across LANES signed lanes per transaction; successor to the single-lane warp ALU.
- Sits between the warp operand collector and the writeback stage.
- Adds a valid/ready handshake with backpressure, per-lane masking, selectable saturation, per-lane overflow flags, sticky status and an overflow event counter.

Parameters:
- WIDTH, 32, lane width in bits; signed two's complement; must be >= 8.
- LANES, 4, number of parallel lanes; must be >= 1.
- LATENCY, 2, pipeline depth in cycles from input accept to output valid; must be >= 1.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  ALU can accept an input this cycle.
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 FMA, 4 MAX, 5 MIN, 6 RELU, 7 PASS.
- in_sat  in  1  1 = clamp overflowed results; 0 = wrap.
- in_mask  in  LANES  lane enable; bit i covers lane i.
- in_a, in_b, in_c  in  LANES*WIDTH  operands; lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  LANES*WIDTH  per-lane results.
- out_ovf  out  LANES  per-lane overflow flag of the current result.
- clr_status  in  1  synchronous clear of sticky_ovf and ovf_count.
- sticky_ovf  out  LANES  per-lane OR of all overflows since reset or clear.
- ovf_count  out  CNT_W  count of accepted output transactions with any out_ovf bit set; saturates at all-ones.

Behaviour:
- Reset (rst=1, asynchronous): all pipeline valid bits = 0, out_valid = 0, out_result = 0, out_ovf = 0, sticky_ovf = 0, ovf_count = 0. Data in flight is discarded.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - out_result and out_ovf hold stable while out_valid && !out_ready.
- Pipeline control:
  - The pipeline uses a single global enable: adv = !out_valid || out_ready, and in_ready = adv.
  - When adv=1, every stage shifts by one; stage 0 captures the input valid bit as in_valid && in_ready.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
  - Latency is exactly LATENCY cycles when unstalled. Throughput is 1 transaction per cycle.
- Arithmetic (per lane):
  - Compute at stage 0 in 2*WIDTH+1 bits, signed.
  - The remaining LATENCY-1 stages are registers only.
- Per-opcode results:
  - ADD: a+b.
  - SUB: a-b.
  - MUL: low WIDTH bits of a*b.
  - FMA: a*b+c, where the full 2*WIDTH product is added to sign-extended c.
  - MAX / MIN: signed compare of a and b.
  - RELU: a if a >= 0, else 0.
  - PASS: a.
- Overflow:
  - A lane overflows when the exact result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; this is only possible for ADD, SUB, MUL and FMA.
  - MAX, MIN, RELU and PASS never overflow.
- Saturation:
  - in_sat=1 on overflow: result clamps to max positive if the exact result > 0, else to min negative. out_ovf is still 1.
  - in_sat=0: result is the low WIDTH bits of the exact result.
- Masked lanes (in_mask[i]=0): result 0, out_ovf[i]=0; the lane never contributes to status.
- Status update, on each output handshake:
  - sticky_ovf |= out_ovf.
  - If |out_ovf, ovf_count increments, holding at 2^CNT_W-1.
  - clr_status has priority over a same-cycle update: the register clears and that cycle's event is lost.
- in_op, in_sat and in_mask are sampled only at acceptance; changing them mid-flight has no effect on in-flight transactions.

Test Plan:
- Reset, then one ADD, MUL and FMA with out_ready=1: ADD lane0 a=0x10, b=0x20 → 0x30. MUL a=5, b=6 → 0x1E. FMA a=2, b=3, c=4 → 0xA. Each out_valid arrives exactly 2 cycles after acceptance; out_ovf=0.
- ADD a=0x7FFFFFFF, b=1:
  - in_sat=0 → 0x80000000 with out_ovf=1.
  - in_sat=1 → 0x7FFFFFFF with out_ovf=1.
  - MUL a=0x80000000, b=-1 with in_sat=1 → 0x7FFFFFFF with out_ovf=1.
  - After these three outputs: sticky_ovf[0]=1 and ovf_count=3.
- Four lanes, MAX/MIN/RELU:
  - a={-1,5,0x10,-7}, b={0,5,0x20,-8}.
  - MAX → {0,5,0x20,-7}. MIN → {-1,5,0x10,-8}. RELU on a → {0,5,0x10,0}.
  - in_mask=4'b0101 zeroes lanes 1 and 3 of the result.
- Backpressure: stream 6 back-to-back ADDs with out_ready held 0 for 4 cycles mid-stream.
  - in_ready drops whenever out_valid && !out_ready.
  - out_result holds stable while stalled.
  - All 6 results arrive in order with none lost or duplicated.
- Assert rst for 1 cycle with 2 transactions in flight: out_valid=0 immediately (asynchronous), and no stale result appears afterwards.
- CNT_W=2:
  - 5 overflowing transactions → ovf_count saturates at 3.
  - clr_status in the same cycle as an overflowing output → ovf_count=0 and sticky_ovf=0.
